rx_buffer_fifo: RTL and testbench
=================================

Name: rx_buffer_fifo

Overview:
- Receive-side sink directly downstream of RX_channel. Captures each beat that RX_channel reports on rx_data/rx_new_data into a circular FIFO.
- Drains the FIFO to the memory write port using a valid/busy handshake.
- Drives rx_hold back to RX_channel with a margin, so in-flight beats are never lost.
- Replaces the ad-hoc memory-storage behaviour on the receive path with real buffering.

Parameters:
- WIDTH, 8, data beat width; must match RX_channel WIDTH
- DEPTH, 8, FIFO entries; power of two, minimum 4
- HOLD_MARGIN, 2, free entries reserved for beats already in flight when rx_hold rises; range 1..DEPTH-1

Ports:
- ACLK  in  1  clock; all state updates on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- rx_data  in  WIDTH  beat from RX_channel
- rx_new_data  in  1  one-cycle strobe: rx_data is valid this cycle
- rx_hold  out  1  to RX_channel: stop accepting new beats
- mem_data  out  WIDTH  head-of-FIFO data to memory
- mem_wr  out  1  mem_data valid (FIFO not empty)
- mem_busy  in  1  memory cannot take a beat this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a beat was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Storage: DEPTH x WIDTH array; write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0; count register separate.
- Reset (async, ARESET=1):
  - wp=0, rp=0, count=0, overflow=0.
  - rx_hold=0, mem_wr=0, mem_data=0.
  - Array contents are don't-care.
  - Asserting reset mid-transfer discards all buffered beats immediately.
- push = rx_new_data && (count<DEPTH || pop). Write the array at wp and increment wp.
- pop = mem_wr && !mem_busy. Increment rp.
- count_next = count + push - pop.
- Push and pop in the same cycle:
  - When full: both take effect, count stays DEPTH, and the data ordering is preserved.
  - When empty: no pop is possible because mem_wr=0. The push lands and count becomes 1.
- Full drop: rx_new_data while count==DEPTH and no pop:
  - beat discarded; wp and count unchanged;
  - overflow=1 from the next cycle.
- overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf=1 clears it next cycle.
- Drain side (show-ahead):
  - mem_wr = (count!=0), combinational from the count register.
  - mem_data = array[rp] while mem_wr=1, else 0.
  - mem_data and mem_wr hold stable while mem_busy=1.
- Latency: a beat pushed at edge N is visible on mem_wr/mem_data after edge N (cycle N+1). There is no bypass from rx_data to mem_data.
- rx_hold:
  - Registered; rx_hold_next = (count_next >= DEPTH-HOLD_MARGIN).
  - Deasserts the cycle after count_next drops below the threshold.
- Flow-control contract: RX_channel may deliver up to HOLD_MARGIN beats after rx_hold rises. With a compliant RX_channel, overflow never sets.
- count==DEPTH while rx_hold=0 is unreachable for HOLD_MARGIN>=1.
- No X propagation: mem_data is forced to 0 when empty.

Test Plan:
- Reset then idle, with ARESET pulsed high for 2 cycles: all outputs 0, count=0. Asserting ARESET with count=5 clears count, mem_wr and rx_hold within the same cycle (async).
- Streaming, with mem_busy=0 and beats 0x11,0x22,0x33 on consecutive cycles: mem_wr high from the cycle after the first strobe; mem_data shows 0x11, 0x22, 0x33 in order; count never exceeds 1; rx_hold stays 0.
- Fill to threshold, with mem_busy=1 and 6 beats 0xA0..0xA5 (DEPTH=8, HOLD_MARGIN=2): rx_hold=1 in the cycle after the 6th push. Two further beats bring count to 8 and overflow stays 0. Releasing mem_busy drains 0xA0..0xA7 in order, and rx_hold drops when count falls below 6.
- Overflow: with count=8 and mem_busy=1, one extra beat 0xFF is dropped, count stays 8, and overflow=1 next cycle. clr_ovf for 1 cycle gives overflow=0. Draining yields no 0xFF.
- Simultaneous push/pop when full: count=8, mem_busy=0, strobe 0x5A in the same cycle. count stays 8, overflow stays 0, and 0x5A emerges as the 8th beat after the current head.
- Pointer wrap: push and drain 20 beats (an incrementing pattern) with random mem_busy. The output sequence matches the input exactly across 2+ wraps, and count returns to 0.

Source files
------------

// File: rtl/rx_buffer_fifo.sv
// rx_buffer_fifo: circular receive buffer between RX_channel and the memory write port.
// Show-ahead drain, registered early-hold back-pressure and a sticky overflow flag.
module rx_buffer_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int HOLD_MARGIN = 2
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_new_data,
    output logic                     rx_hold,
    output logic [WIDTH-1:0]         mem_data,
    output logic                     mem_wr,
    input  logic                     mem_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH = CW'(DEPTH - HOLD_MARGIN);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             hold_q, hold_d;
    logic             push, pop, drop;

    assign mem_wr   = (count_q != '0);
    assign mem_data = mem_wr ? mem_q[rp_q] : '0;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rx_hold  = hold_q;

    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign pop  = mem_wr && !mem_busy;
    assign push = rx_new_data && ((count_q != FULL) || pop);
    assign drop = rx_new_data && !push;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q + CW'(push) - CW'(pop);
        ovf_d   = ovf_q;
        if (push) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        hold_d = (count_d >= THRESH);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wp_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_rx_buffer_fifo.sv
// tb_rx_buffer_fifo: directed checks of rx_buffer_fifo (DEPTH=8, HOLD_MARGIN=2).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_rx_buffer_fifo;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [7:0] rx_data;
    logic       rx_new_data;
    logic       rx_hold;
    logic [7:0] mem_data;
    logic       mem_wr;
    logic       mem_busy;
    logic [3:0] count;
    logic       overflow;
    logic       clr_ovf;

    int n_vec = 0;
    int n_err = 0;

    rx_buffer_fifo #(.WIDTH(8), .DEPTH(8), .HOLD_MARGIN(2)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .rx_data     (rx_data),
        .rx_new_data (rx_new_data),
        .rx_hold     (rx_hold),
        .mem_data    (mem_data),
        .mem_wr      (mem_wr),
        .mem_busy    (mem_busy),
        .count       (count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        mem_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            rx_data     = base + 8'(i);
            rx_new_data = 1'b1;
            tick();
        end
        rx_new_data = 1'b0;
    endtask

    logic [7:0] q[$];
    int sent, rcvd, cyc;
    logic [7:0] exp_b;

    initial begin
        ARESET      = 1'b1;
        rx_data     = '0;
        rx_new_data = 1'b0;
        mem_busy    = 1'b0;
        clr_ovf     = 1'b0;
        #2;
        chk("rst_async_count", count, 0);
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_hold", rx_hold, 0);
        chk("rst_ovf", overflow, 0);

        // Streaming with the memory always ready
        rx_new_data = 1'b1;
        rx_data = 8'h11;
        tick();
        chk("st_wr1", mem_wr, 1);
        chk("st_d1", mem_data, 8'h11);
        chk("st_c1", count, 1);
        rx_data = 8'h22;
        tick();
        chk("st_d2", mem_data, 8'h22);
        chk("st_c2", count, 1);
        rx_data = 8'h33;
        tick();
        chk("st_d3", mem_data, 8'h33);
        chk("st_c3", count, 1);
        chk("st_hold", rx_hold, 0);
        rx_new_data = 1'b0;
        tick();
        chk("st_empty_c", count, 0);
        chk("st_empty_wr", mem_wr, 0);
        chk("st_empty_d", mem_data, 0);

        // Fill to threshold, then to full
        fill(8'hA0, 5);
        chk("fill5_c", count, 5);
        chk("fill5_hold", rx_hold, 0);
        rx_data = 8'hA5;
        rx_new_data = 1'b1;
        tick();
        rx_new_data = 1'b0;
        chk("fill6_hold", rx_hold, 1);
        fill(8'hA6, 2);
        chk("fill8_c", count, 8);
        chk("fill8_ovf", overflow, 0);
        chk("fill8_head", mem_data, 8'hA0);

        // Overflow drop and clear
        rx_data = 8'hFF;
        rx_new_data = 1'b1;
        tick();
        rx_new_data = 1'b0;
        chk("ovf_c", count, 8);
        chk("ovf_set", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);

        mem_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("drain_d", mem_data, 8'hA0 + 8'(i));
            tick();
            chk("drain_c", count, 7 - i);
            chk("drain_hold", rx_hold, (7 - i) >= 6);
        end
        chk("drain_wr", mem_wr, 0);

        // Push and pop together while full
        fill(8'hB0, 8);
        chk("pp_full", count, 8);
        mem_busy = 1'b0;
        rx_data = 8'h5A;
        rx_new_data = 1'b1;
        tick();
        rx_new_data = 1'b0;
        chk("pp_c", count, 8);
        chk("pp_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            exp_b = (i == 7) ? 8'h5A : 8'hB1 + 8'(i);
            chk("pp_d", mem_data, exp_b);
            tick();
        end
        chk("pp_end", count, 0);

        // Asynchronous reset in the middle of a cycle
        fill(8'hC0, 5);
        chk("ar_c5", count, 5);
        #2 ARESET = 1'b1;
        #1;
        chk("ar_c", count, 0);
        chk("ar_wr", mem_wr, 0);
        chk("ar_hold", rx_hold, 0);
        chk("ar_d", mem_data, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        tick();

        // Wrap: 20 beats, random memory stalls, compliant sender
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 20 && cyc < 500) begin
            mem_busy = 1'($urandom_range(0, 1));
            if (mem_wr && !mem_busy) begin
                if (q.size() == 0) begin
                    chk("wrap_extra", mem_data, 32'hDEAD);
                end else begin
                    chk("wrap_d", mem_data, q.pop_front());
                end
                rcvd++;
            end
            if (sent < 20 && !rx_hold) begin
                rx_data = 8'h40 + 8'(sent);
                rx_new_data = 1'b1;
                q.push_back(rx_data);
                sent++;
            end else begin
                rx_new_data = 1'b0;
            end
            tick();
            cyc++;
        end
        rx_new_data = 1'b0;
        mem_busy = 1'b0;
        chk("wrap_timeout", cyc < 500, 1);
        chk("wrap_c", count, 0);
        chk("wrap_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
